// File: rtl/gate_sweep_pkg.sv
// Purpose: shared types and constants for the two-input gate sweep controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Width of the settle counter; covers SETTLE_CYCLES 0..15.
  localparam int CNT_W = 4;

  // Gray-ordered input vectors {inp1,inp2}: entry 0 in the low bits -> 00, 01, 11, 10.
  localparam logic [7:0] VEC_ORDER = {2'b10, 2'b11, 2'b01, 2'b00};

  // Returns the {inp1,inp2} pair for sweep step idx.
  function automatic logic [1:0] vec_at(input logic [1:0] idx);
    return VEC_ORDER[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/sweep_timer.sv
// Purpose: settle down-counter with load, decrement and zero flag.
// Latency: load/decrement take effect on the next rising edge; zero flag is combinational from the count.
// Backpressure: none; load has priority over decrement, decrement stops at zero.
module sweep_timer
  import gate_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Counter register: reload on request, otherwise count down to zero and stay there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Purpose: drives a 2-input gate through 00,01,11,10 and compares its output to an expected truth table.
// Latency: done pulses 4*(SETTLE_CYCLES+1)+... i.e. at edge k+4*(SETTLE_CYCLES+1) after the start edge k.
// Backpressure: start is only accepted in IDLE; requests while busy or finishing are dropped.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expect_func,
  output logic       gate_inp1,
  output logic       gate_inp2,
  input  logic       gate_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_accept;
  logic       w_sample;
  logic       w_busy;
  logic       w_done;
  logic       w_last;
  logic       w_tmr_zero;
  logic       w_mis;
  logic [2:0] w_err_nxt;
  logic [1:0] w_vec_nxt;

  logic       r_inp1;
  logic       r_inp2;
  logic [3:0] r_exp;
  logic [1:0] r_idx;
  logic [2:0] r_err;
  logic [3:0] r_fail;
  logic       r_pass;

  // Settle timer: reloaded on start and at every sample, counts down while holding a vector.
  sweep_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept | w_sample),
    .i_load_val (SETTLE_LD),
    .i_dec      (w_busy),
    .o_zero     (w_tmr_zero)
  );

  assign w_last    = (r_idx == 2'd3);
  assign w_mis     = (gate_out != r_exp[{r_inp1, r_inp2}]);
  // The sweep has four vectors, so the count cannot pass 4; hold there anyway rather than wrap.
  assign w_err_nxt = (r_err == 3'd4) ? r_err : (r_err + {2'b00, w_mis});
  assign w_vec_nxt = vec_at(r_idx + 2'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_busy = 1'b1;
        if (w_tmr_zero) begin
          w_sample = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sweep datapath: vector drive, expected-table latch, and result accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inp1 <= 1'b0;
      r_inp2 <= 1'b0;
      r_exp  <= '0;
      r_idx  <= '0;
      r_err  <= '0;
      r_fail <= '0;
      r_pass <= 1'b0;
    end else if (w_accept) begin
      r_exp  <= expect_func;
      r_idx  <= '0;
      r_err  <= '0;
      r_fail <= '0;
      r_inp1 <= 1'b0;
      r_inp2 <= 1'b0;
    end else if (w_sample) begin
      if (w_mis) begin
        r_fail[{r_inp1, r_inp2}] <= 1'b1;
      end
      r_err <= w_err_nxt;
      r_idx <= r_idx + 2'd1;
      if (w_last) begin
        r_inp1 <= 1'b0;
        r_inp2 <= 1'b0;
        r_pass <= (w_err_nxt == 3'd0);
      end else begin
        r_inp1 <= w_vec_nxt[1];
        r_inp2 <= w_vec_nxt[0];
      end
    end
  end

  assign gate_inp1 = r_inp1;
  assign gate_inp2 = r_inp2;
  assign busy      = w_busy;
  assign done      = w_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Purpose: directed, table-driven bench for gate_sweep_ctrl with a modelled gate under test.
// Latency: checks done at start edge + 4*(SETTLE_CYCLES+1) for SETTLE_CYCLES 2 and 0.
// Backpressure: checks that start during a sweep or in FINISH is dropped.
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: SETTLE_CYCLES=2, gate modelled by an arbitrary truth table gfn_a.
  logic       start_a;
  logic [3:0] ef_a;
  logic [3:0] gfn_a;
  logic       in1_a, in2_a, out_a, busy_a, done_a, pass_a;
  logic [2:0] err_a;
  logic [3:0] fv_a;
  assign out_a = gfn_a[{in1_a, in2_a}];

  // Instance B: SETTLE_CYCLES=0, AND gate.
  logic       start_b;
  logic [3:0] ef_b;
  logic       in1_b, in2_b, out_b, busy_b, done_b, pass_b;
  logic [2:0] err_b;
  logic [3:0] fv_b;
  assign out_b = in1_b & in2_b;

  gate_sweep_ctrl #(.SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .expect_func(ef_a),
    .gate_inp1(in1_a), .gate_inp2(in2_a), .gate_out(out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .fail_vec(fv_a)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expect_func(ef_b),
    .gate_inp1(in1_b), .gate_inp2(in2_b), .gate_out(out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .fail_vec(fv_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] vec_tb [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  typedef struct {
    logic [3:0] gfn;
    logic [3:0] ef;
    logic       pass;
    logic [2:0] err;
    logic [3:0] fv;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
  endtask

  // One full sweep on instance A with per-cycle checks of {inp1,inp2,busy,done}.
  task automatic run_sweep(input logic [3:0] gfn, input logic [3:0] ef, input logic e_pass,
                           input logic [2:0] e_err, input logic [3:0] e_fv, input bit inject,
                           input string nm);
    @(negedge clk);
    gfn_a   = gfn;
    ef_a    = ef;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    ef_a    = ~ef;  // must not matter after the start edge
    for (int t = 0; t < 12; t++) begin
      chk($sformatf("%s seq t=%0d", nm, t), {in1_a, in2_a, busy_a, done_a}, {vec_tb[t/3], 2'b10});
      if (inject && t == 3) start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    chk($sformatf("%s finish", nm), {in1_a, in2_a, busy_a, done_a}, 4'b0001);
    chk($sformatf("%s pass", nm), pass_a, e_pass);
    chk($sformatf("%s err_count", nm), err_a, e_err);
    chk($sformatf("%s fail_vec", nm), fv_a, e_fv);
    if (inject) start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk($sformatf("%s idle", nm), {in1_a, in2_a, busy_a, done_a}, 4'b0000);
    chk($sformatf("%s held", nm), {pass_a, err_a, fv_a}, {e_pass, e_err, e_fv});
    if (inject) begin
      @(negedge clk);
      chk($sformatf("%s no requeue", nm), {busy_a, done_a}, 2'b00);
      chk($sformatf("%s held2", nm), {pass_a, err_a, fv_a}, {e_pass, e_err, e_fv});
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    ef_a    = 4'h0;
    ef_b    = 4'h0;
    gfn_a   = 4'h0;

    repeat (2) @(negedge clk);
    chk("reset A", {in1_a, in2_a, busy_a, done_a, pass_a, err_a, fv_a}, 0);
    chk("reset B", {in1_b, in2_b, busy_b, done_b, pass_b, err_b, fv_b}, 0);
    rst_n = 1'b1;

    //          gate    expect  pass  err   fail_vec
    tbl[0] = '{4'b1000, 4'b1000, 1'b1, 3'd0, 4'b0000};  // AND vs AND
    tbl[1] = '{4'b1000, 4'b1110, 1'b0, 3'd2, 4'b0110};  // AND vs OR
    tbl[2] = '{4'b1000, 4'b0111, 1'b0, 3'd4, 4'b1111};  // AND vs NAND: every vector wrong
    tbl[3] = '{4'b0110, 4'b0110, 1'b1, 3'd0, 4'b0000};  // XOR vs XOR
    tbl[4] = '{4'b0110, 4'b0000, 1'b0, 3'd2, 4'b0110};  // XOR vs constant 0
    tbl[5] = '{4'b1110, 4'b1000, 1'b0, 3'd2, 4'b0110};  // OR vs AND
    tbl[6] = '{4'b0001, 4'b0000, 1'b0, 3'd1, 4'b0001};  // NOR, mismatch only at 00
    tbl[7] = '{4'b1000, 4'b0000, 1'b0, 3'd1, 4'b1000};  // AND, mismatch only at 11

    for (int i = 0; i < 8; i++) begin
      run_sweep(tbl[i].gfn, tbl[i].ef, tbl[i].pass, tbl[i].err, tbl[i].fv, 1'b0,
                $sformatf("tbl%0d", i));
    end

    // Start pulses during HOLD and in FINISH must be dropped.
    run_sweep(4'b1000, 4'b1110, 1'b0, 3'd2, 4'b0110, 1'b1, "ignore_start");

    // Reset in the middle of a sweep: outputs clear, no done ever appears.
    @(negedge clk);
    gfn_a   = 4'b1000;
    ef_a    = 4'b1110;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset outputs", {in1_a, in2_a, busy_a, done_a, pass_a, err_a, fv_a}, 0);
    rst_n = 1'b1;
    begin
      int n_done = 0;
      for (int t = 0; t < 14; t++) begin
        @(negedge clk);
        if (done_a || busy_a) n_done++;
      end
      chk("midreset no done", n_done, 0);
    end
    run_sweep(4'b1000, 4'b1000, 1'b1, 3'd0, 4'b0000, 1'b0, "after_reset");

    // SETTLE_CYCLES=0: one cycle per vector, done four cycles after start.
    @(negedge clk);
    ef_b    = 4'b1110;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("s0 seq t=%0d", t), {in1_b, in2_b, busy_b, done_b}, {vec_tb[t], 2'b10});
      @(negedge clk);
    end
    chk("s0 finish", {in1_b, in2_b, busy_b, done_b}, 4'b0001);
    chk("s0 results", {pass_b, err_b, fv_b}, {1'b0, 3'd2, 4'b0110});
    @(negedge clk);
    chk("s0 idle", {busy_b, done_b}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
